// File: rtl/trigger_delay_multi_pkg.sv
// Shared types and helpers for the multi-channel trigger delay generator.
package trigger_delay_multi_pkg;

    typedef enum logic [1:0] {
        DISABLED   = 2'b00,
        ONESHOT    = 2'b01,
        CONTINUOUS = 2'b10,
        RSVD       = 2'b11
    } ch_mode_e;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'b00,
        ST_ARMED    = 2'b01,
        ST_SPENT    = 2'b10
    } ch_state_e;

    localparam int MIN_DELAY = 1;

    // A zero-length pulse would be invisible downstream, so it is stretched to one cycle.
    function automatic logic [31:0] clamp_width(input logic [31:0] w);
        return (w == '0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/trigger_delay_channel.sv
// One delay channel: mode FSM, FIFO of target timestamps, shadow/active config
// and the output pulse timer.
module trigger_delay_channel
    import trigger_delay_multi_pkg::*;
#(
    parameter int DELAY_W     = 32,
    parameter int QUEUE_DEPTH = 8,
    parameter int WIDTH_W     = 16,
    parameter int PEND_W      = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [DELAY_W-1:0] ts_i,
    input  logic               trig_i,
    input  logic [DELAY_W-1:0] cfg_delay_i,
    input  logic [WIDTH_W-1:0] cfg_width_i,
    input  logic               cfg_update_i,
    input  logic [1:0]         cfg_mode_i,
    input  logic               arm_i,
    input  logic               clear_overflow_i,
    output logic               trigger_o,
    output logic               busy_o,
    output logic               overflow_o,
    output logic [PEND_W-1:0]  pending_o
);
    localparam int AW = $clog2(QUEUE_DEPTH);

    ch_mode_e           mode;
    ch_state_e          state_q;
    logic [DELAY_W-1:0] fifo_q [QUEUE_DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PEND_W-1:0]  count_q, count_d;
    logic               mode_off, full, pop, accept_ok, push, ovf_set;
    logic [DELAY_W-1:0] target;
    logic [DELAY_W-1:0] dly_act_q, dly_shd_q, dly_src;
    logic [WIDTH_W-1:0] wid_act_q, wid_shd_q, wid_src;
    logic               shd_dirty_q, cfg_pend, cfg_apply;
    logic               out_q, ovf_q;
    logic [WIDTH_W-1:0] pcnt_q;

    assign mode = ch_mode_e'(cfg_mode_i);

    always_comb begin
        mode_off  = (mode == DISABLED) || (mode == RSVD);
        full      = (count_q == PEND_W'(QUEUE_DEPTH));
        pop       = !mode_off && (count_q != '0) && (fifo_q[rd_ptr_q] == ts_i);
        accept_ok = trig_i && !mode_off && (state_q == ST_ARMED);
        push      = accept_ok && (!full || pop);
        ovf_set   = accept_ok && full && !pop;
        target    = ts_i + dly_act_q;
        // New config only takes effect on an idle queue so queued targets stay in firing order.
        cfg_pend  = cfg_update_i || shd_dirty_q;
        cfg_apply = cfg_pend && (count_q == '0) && !push;
        dly_src   = cfg_update_i ? cfg_delay_i : dly_shd_q;
        wid_src   = cfg_update_i ? cfg_width_i : wid_shd_q;
        count_d   = count_q;
        if (mode_off) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + PEND_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - PEND_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_DISABLED;
        end else begin
            case (state_q)
                ST_DISABLED: if (!mode_off) state_q <= ST_ARMED;
                ST_ARMED: begin
                    if (mode_off)                        state_q <= ST_DISABLED;
                    else if (push && (mode == ONESHOT))  state_q <= ST_SPENT;
                end
                ST_SPENT: begin
                    if (mode_off)                               state_q <= ST_DISABLED;
                    else if (arm_i || (mode == CONTINUOUS))     state_q <= ST_ARMED;
                end
                default: state_q <= ST_DISABLED;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (mode_off) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= target;
    end

    always_ff @(posedge clk_i) begin
        if (cfg_update_i) begin
            dly_shd_q <= cfg_delay_i;
            wid_shd_q <= cfg_width_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shd_dirty_q <= 1'b0;
            dly_act_q   <= DELAY_W'(MIN_DELAY);
            wid_act_q   <= WIDTH_W'(1);
        end else begin
            shd_dirty_q <= cfg_pend && !cfg_apply;
            if (cfg_apply) begin
                dly_act_q <= (dly_src == '0) ? DELAY_W'(MIN_DELAY) : dly_src;
                wid_act_q <= WIDTH_W'(clamp_width(32'(wid_src)));
            end
        end
    end

    // A fire while the pulse is running reloads the counter, so the output never dips.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q  <= 1'b0;
            pcnt_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (pop) begin
                out_q  <= 1'b1;
                pcnt_q <= wid_act_q - WIDTH_W'(1);
            end else if (out_q) begin
                if (pcnt_q == '0) out_q  <= 1'b0;
                else              pcnt_q <= pcnt_q - WIDTH_W'(1);
            end
            ovf_q <= ovf_set || (ovf_q && !clear_overflow_i);
        end
    end

    assign trigger_o  = out_q;
    assign busy_o     = (count_q != '0) || out_q;
    assign overflow_o = ovf_q;
    assign pending_o  = count_q;

endmodule

// File: rtl/trigger_delay_multi.sv
// Multi-channel, multi-outstanding trigger delay generator: a shared free-running
// timestamp feeding NUM_CH independent delay channels.
module trigger_delay_multi
    import trigger_delay_multi_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DELAY_W     = 32,
    parameter int QUEUE_DEPTH = 8,
    parameter int WIDTH_W     = 16
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic [NUM_CH-1:0]                                trig_pulse,
    input  logic [NUM_CH-1:0][DELAY_W-1:0]                   cfg_delay,
    input  logic [NUM_CH-1:0][WIDTH_W-1:0]                   cfg_width,
    input  logic [NUM_CH-1:0]                                cfg_update,
    input  logic [NUM_CH-1:0][1:0]                           cfg_mode,
    input  logic [NUM_CH-1:0]                                arm,
    input  logic [NUM_CH-1:0]                                clear_overflow,
    output logic [NUM_CH-1:0]                                trigger_out,
    output logic [NUM_CH-1:0]                                busy,
    output logic [NUM_CH-1:0]                                overflow,
    output logic [NUM_CH-1:0][$clog2(QUEUE_DEPTH+1)-1:0]     pending
);
    logic [DELAY_W-1:0] ts_q;

    // Wraps modulo 2^DELAY_W; channels compare for equality only, so wrap is harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_q <= '0;
        else        ts_q <= ts_q + DELAY_W'(1);
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        trigger_delay_channel #(
            .DELAY_W     (DELAY_W),
            .QUEUE_DEPTH (QUEUE_DEPTH),
            .WIDTH_W     (WIDTH_W)
        ) u_ch (
            .clk_i            (clk),
            .rst_ni           (rst_n),
            .ts_i             (ts_q),
            .trig_i           (trig_pulse[c]),
            .cfg_delay_i      (cfg_delay[c]),
            .cfg_width_i      (cfg_width[c]),
            .cfg_update_i     (cfg_update[c]),
            .cfg_mode_i       (cfg_mode[c]),
            .arm_i            (arm[c]),
            .clear_overflow_i (clear_overflow[c]),
            .trigger_o        (trigger_out[c]),
            .busy_o           (busy[c]),
            .overflow_o       (overflow[c]),
            .pending_o        (pending[c])
        );
    end

endmodule

// File: tb/tb_trigger_delay_multi.sv
// Directed bench for trigger_delay_multi: expected pulses are queued as triggers
// are driven and matched against observed rising/falling edges of channel 0.
module tb_trigger_delay_multi;
    localparam int NCH = 2;
    localparam int DW  = 8;
    localparam int QD  = 8;
    localparam int WW  = 8;
    localparam int PW  = $clog2(QD + 1);

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NCH-1:0]          trig_pulse, cfg_update, arm, clear_overflow;
    logic [NCH-1:0][DW-1:0]  cfg_delay;
    logic [NCH-1:0][WW-1:0]  cfg_width;
    logic [NCH-1:0][1:0]     cfg_mode;
    logic [NCH-1:0]          trigger_out, busy, overflow;
    logic [NCH-1:0][PW-1:0]  pending;

    typedef struct {
        int rise;
        int len;
    } exp_t;

    exp_t exp_q[$];
    int   cyc, n_assert, n_fail, rise_cyc, cur_len, ch1_high;
    logic prev0;

    trigger_delay_multi #(
        .NUM_CH(NCH), .DELAY_W(DW), .QUEUE_DEPTH(QD), .WIDTH_W(WW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .trig_pulse     (trig_pulse),
        .cfg_delay      (cfg_delay),
        .cfg_width      (cfg_width),
        .cfg_update     (cfg_update),
        .cfg_mode       (cfg_mode),
        .arm            (arm),
        .clear_overflow (clear_overflow),
        .trigger_out    (trigger_out),
        .busy           (busy),
        .overflow       (overflow),
        .pending        (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Edge monitor for channel 0; channel 1 is kept disabled and must never fire.
    task automatic monitor();
        logic t0;
        exp_t e;
        t0 = trigger_out[0];
        if (t0 && !prev0) begin
            check("rise_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rise_cycle", cyc, e.rise);
                cur_len = e.len;
            end
            rise_cyc = cyc;
        end else if (!t0 && prev0) begin
            check("pulse_len", cyc - rise_cyc, cur_len);
        end
        prev0 = t0;
        if (trigger_out[1] !== 1'b0) ch1_high++;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) tick();
    endtask

    task automatic pulse(input int lat, input int len, input bit expect_rise);
        exp_t e;
        if (expect_rise) begin
            e.rise = cyc + lat;
            e.len  = len;
            exp_q.push_back(e);
        end
        trig_pulse = '1;
        tick();
        trig_pulse = '0;
    endtask

    task automatic set_cfg(input logic [1:0] mode, input int d, input int w);
        cfg_mode[0]   = mode;
        cfg_delay[0]  = DW'(d);
        cfg_width[0]  = WW'(w);
        cfg_update[0] = 1'b1;
        tick();
        cfg_update[0] = 1'b0;
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        trig_pulse = '0; cfg_update = '0; arm = '0; clear_overflow = '0;
        cfg_delay = '0; cfg_width = '0; cfg_mode = '0;
        cyc = 0; n_assert = 0; n_fail = 0; rise_cyc = 0; cur_len = 0; ch1_high = 0;
        prev0 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_trigger_out", 32'(trigger_out), 32'd0);
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_overflow",    32'(overflow),    32'd0);
        check("rst_pending",     32'(pending),     32'd0);
        rst_n = 1'b1;
        cyc = 0;   // timestamp is 0 in this cycle, so ts(cyc) == cyc mod 256

        // Single pulse: delay 10, width 3
        wait_until(10);  set_cfg(2'b10, 10, 3);
        wait_until(100); pulse(11, 3, 1'b1);
        wait_until(113);
        check("t1_out_high_113", 32'(trigger_out[0]), 32'd1);
        check("t1_busy_113",     32'(busy[0]),        32'd1);
        wait_until(114);
        check("t1_out_low_114",  32'(trigger_out[0]), 32'd0);
        check("t1_busy_low_114", 32'(busy[0]),        32'd0);

        // Multiple outstanding triggers within one delay window
        wait_until(150); set_cfg(2'b10, 20, 2);
        wait_until(200); pulse(21, 2, 1'b1);
        wait_until(205); pulse(21, 2, 1'b1);
        wait_until(209); pulse(21, 2, 1'b1);
        wait_until(210);
        check("t2_pending_peak", 32'(pending[0]), 32'd3);
        check("t2_ch1_pending",  32'(pending[1]), 32'd0);
        wait_until(232);
        check("t2_pending_zero", 32'(pending[0]), 32'd0);
        check("t2_busy_low",     32'(busy[0]),    32'd0);

        // Overflow: 9 back-to-back triggers; fires on consecutive cycles merge into one 8-cycle pulse
        wait_until(250); set_cfg(2'b10, 100, 1);
        wait_until(300);
        for (int i = 0; i < 9; i++) pulse(101, 8, i == 0);
        check("t3_overflow_set", 32'(overflow[0]), 32'd1);
        check("t3_pending_full", 32'(pending[0]),  32'd8);
        wait_until(350); clear_overflow[0] = 1'b1; tick(); clear_overflow[0] = 1'b0;
        check("t3_overflow_cleared", 32'(overflow[0]), 32'd0);
        wait_until(360);
        clear_overflow[0] = 1'b1;
        pulse(0, 0, 1'b0);
        clear_overflow[0] = 1'b0;
        check("t3_clear_vs_set", 32'(overflow[0]), 32'd1);
        check("t3_still_full",   32'(pending[0]),  32'd8);
        wait_until(370); clear_overflow[0] = 1'b1; tick(); clear_overflow[0] = 1'b0;
        check("t3_overflow_cleared2", 32'(overflow[0]), 32'd0);
        wait_until(400); pulse(101, 1, 1'b1);   // full queue, head pops this cycle
        check("t3_pushpop_no_ovf", 32'(overflow[0]), 32'd0);
        check("t3_pushpop_full",   32'(pending[0]),  32'd8);
        wait_until(408);
        check("t3_pending_drain", 32'(pending[0]), 32'd1);

        // One-shot with re-arm
        wait_until(520); set_cfg(2'b01, 5, 2);
        wait_until(600); pulse(6, 2, 1'b1);
        check("t4_pending_one", 32'(pending[0]), 32'd1);
        wait_until(602); pulse(0, 0, 1'b0);
        check("t4_spent_ignores", 32'(pending[0]), 32'd1);
        wait_until(620); arm[0] = 1'b1; tick(); arm[0] = 1'b0;
        wait_until(630); pulse(6, 2, 1'b1);
        check("t4_rearmed", 32'(pending[0]), 32'd1);

        // Delay 0 clamps to 1; a fire inside a running pulse extends it
        wait_until(650); set_cfg(2'b10, 0, 1);
        wait_until(700); pulse(2, 1, 1'b1);
        wait_until(720); set_cfg(2'b10, 10, 5);
        wait_until(750); pulse(11, 7, 1'b1);
        wait_until(752); pulse(0, 0, 1'b0);

        // Timestamp wrap: trigger at ts == 253, then the maximum delay
        wait_until(800);  set_cfg(2'b10, 6, 1);
        wait_until(1021); pulse(7, 1, 1'b1);
        wait_until(1050); set_cfg(2'b10, 255, 1);
        wait_until(1100); pulse(256, 1, 1'b1);
        check("t5_busy_long", 32'(busy[0]), 32'd1);

        // Config deferred while triggers are queued
        wait_until(1400); set_cfg(2'b10, 50, 1);
        wait_until(1500); pulse(51, 1, 1'b1);
        set_cfg(2'b10, 5, 1);
        pulse(51, 1, 1'b1);
        check("t6_pending_two", 32'(pending[0]), 32'd2);
        wait_until(1560); pulse(6, 1, 1'b1);
        wait_until(1580);
        cfg_delay[0] = DW'(8); cfg_width[0] = WW'(10); cfg_update[0] = 1'b1;
        pulse(6, 1, 1'b1);    // same-cycle update: old delay 5 and width 1 still apply
        cfg_update[0] = 1'b0;

        // Reset mid-pulse: the 10-cycle pulse rising at 1609 is cut after 2 cycles
        wait_until(1600); pulse(9, 2, 1'b1);
        wait_until(1605); pulse(0, 0, 1'b0);
        wait_until(1610);
        check("t6_pending_before_rst", 32'(pending[0]), 32'd1);
        wait_until(1611);
        rst_n = 1'b0;
        #1;
        check("t6_rst_trigger_out", 32'(trigger_out), 32'd0);
        check("t6_rst_busy",        32'(busy),        32'd0);
        check("t6_rst_pending",     32'(pending),     32'd0);
        check("t6_rst_overflow",    32'(overflow),    32'd0);
        tick();
        wait_until(1615); rst_n = 1'b1;
        wait_until(1620); pulse(2, 1, 1'b1);    // reset defaults: delay 1, width 1
        check("t6_after_rst_pending", 32'(pending[0]), 32'd1);

        wait_until(1650);
        check("all_pulses_seen", 32'(exp_q.size()), 32'd0);
        check("ch1_never_fired", 32'(ch1_high),     32'd0);
        check("ch1_no_overflow", 32'(overflow[1]),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
